// File: rtl/output_port_arbiter.sv
// output_port_arbiter
//   Switch allocator for one router output port. Inputs whose head flit is
//   routed to OUTPUT_ID compete for the port. A round-robin pointer picks
//   the winner. The grant is held from head to tail, and this block drives
//   the crossbar select and the valid/ready handshake for that output.
//
//   Optional feature: define ARB_TIMEOUT_EN to add a stall watchdog. It
//   releases a lock after TIMEOUT consecutive cycles without a transfer
//   and pulses timeout_pulse for one cycle.
//
// Ports
//   clk, rst       clock, asynchronous active-high reset
//   req_valid      per input: a decoded head flit is present
//   req_port       per input route code, slice [i*REQUEST_WIDTH +: REQUEST_WIDTH]
//   flit_valid     per input: flit available
//   flit_tail      per input: current flit is the tail
//   out_ready      downstream accepts a flit this cycle
//   out_valid      flit presented on this output
//   flit_ready     per input pop strobe (only the granted input)
//   grant          one-hot granted input (zero when idle)
//   grant_idx      binary crossbar select matching grant
//   grant_valid    a packet currently owns the output
//   timeout_pulse  one-cycle watchdog release strobe (ARB_TIMEOUT_EN only)

module output_port_arbiter #(
  parameter int unsigned NUM_IN        = 5,
  parameter int unsigned REQUEST_WIDTH = 3,
  parameter int unsigned OUTPUT_ID     = 1,
  parameter int unsigned TIMEOUT       = 64
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [NUM_IN-1:0]                 req_valid,
  input  logic [NUM_IN*REQUEST_WIDTH-1:0]   req_port,
  input  logic [NUM_IN-1:0]                 flit_valid,
  input  logic [NUM_IN-1:0]                 flit_tail,
  input  logic                              out_ready,
  output logic                              out_valid,
  output logic [NUM_IN-1:0]                 flit_ready,
  output logic [NUM_IN-1:0]                 grant,
  output logic [$clog2(NUM_IN)-1:0]         grant_idx,
  output logic                              grant_valid
`ifdef ARB_TIMEOUT_EN
  ,
  output logic                              timeout_pulse
`endif
);

  localparam int unsigned IdxW = $clog2(NUM_IN);

  if (NUM_IN < 2 || TIMEOUT < 1) begin : g_param_err
    $error("output_port_arbiter: NUM_IN must be >= 2 and TIMEOUT >= 1");
  end

  typedef enum logic [0:0] {
    StIdle,
    StLocked
  } state_e;

  state_e              r_state, w_state_d;
  logic [NUM_IN-1:0]   r_grant, w_grant_d;
  logic [IdxW-1:0]     r_grant_idx, w_grant_idx_d;
  logic [IdxW-1:0]     r_rr_ptr, w_rr_ptr_d;

  logic [NUM_IN-1:0]   w_cand;
  logic                w_pick_found;
  logic [IdxW-1:0]     w_pick_idx;
  logic [NUM_IN-1:0]   w_pick_oh;
  logic                w_xfer;
  logic                w_tail_xfer;
  logic [IdxW-1:0]     w_ptr_after_g;

  // Candidates: valid head flits routed to this output.
  always_comb begin
    w_cand = '0;
    for (int unsigned i = 0; i < NUM_IN; i++) begin
      w_cand[i] = req_valid[i] &&
                  (req_port[i*REQUEST_WIDTH +: REQUEST_WIDTH] == REQUEST_WIDTH'(OUTPUT_ID));
    end
  end

  // Round-robin pick: the first candidate at or after r_rr_ptr, with wrap.
  always_comb begin
    int unsigned j;
    j            = 0;
    w_pick_found = 1'b0;
    w_pick_idx   = '0;
    w_pick_oh    = '0;
    for (int unsigned k = 0; k < NUM_IN; k++) begin
      j = 32'(r_rr_ptr) + k;
      if (j >= NUM_IN) j = j - NUM_IN;
      if (!w_pick_found && w_cand[j]) begin
        w_pick_found = 1'b1;
        w_pick_idx   = IdxW'(j);
        w_pick_oh[j] = 1'b1;
      end
    end
  end

  // r_grant is all-zero when idle, so these reduce to 0 outside LOCKED.
  assign w_xfer        = (|(r_grant & flit_valid)) && out_ready;
  assign w_tail_xfer   = w_xfer && (|(r_grant & flit_valid & flit_tail));
  assign w_ptr_after_g = (r_grant_idx == IdxW'(NUM_IN - 1)) ? '0 : r_grant_idx + IdxW'(1);

`ifdef ARB_TIMEOUT_EN
  localparam int unsigned CntW = $clog2(TIMEOUT + 1);

  logic [CntW-1:0] r_stall_cnt, w_stall_cnt_d;
  logic            r_timeout_pulse, w_timeout_pulse_d;
`endif

  always_comb begin
    w_state_d     = r_state;
    w_grant_d     = r_grant;
    w_grant_idx_d = r_grant_idx;
    w_rr_ptr_d    = r_rr_ptr;
`ifdef ARB_TIMEOUT_EN
    w_stall_cnt_d     = '0;
    w_timeout_pulse_d = 1'b0;
`endif
    unique case (r_state)
      StIdle: begin
        if (w_pick_found) begin
          w_state_d     = StLocked;
          w_grant_d     = w_pick_oh;
          w_grant_idx_d = w_pick_idx;
        end
      end
      StLocked: begin
        if (w_tail_xfer) begin
          w_state_d     = StIdle;
          w_grant_d     = '0;
          w_grant_idx_d = '0;
          w_rr_ptr_d    = w_ptr_after_g;
        end
`ifdef ARB_TIMEOUT_EN
        else if (!w_xfer) begin
          // Release on the stall that completes TIMEOUT stalled cycles, so the
          // cycle that gets the strobe never pops a flit.
          if (r_stall_cnt == CntW'(TIMEOUT - 1)) begin
            w_state_d         = StIdle;
            w_grant_d         = '0;
            w_grant_idx_d     = '0;
            w_rr_ptr_d        = w_ptr_after_g;
            w_timeout_pulse_d = 1'b1;
          end else begin
            w_stall_cnt_d = r_stall_cnt + CntW'(1);
          end
        end
`endif
      end
      default: begin
        w_state_d     = StIdle;
        w_grant_d     = '0;
        w_grant_idx_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= StIdle;
      r_grant     <= '0;
      r_grant_idx <= '0;
      r_rr_ptr    <= '0;
    end else begin
      r_state     <= w_state_d;
      r_grant     <= w_grant_d;
      r_grant_idx <= w_grant_idx_d;
      r_rr_ptr    <= w_rr_ptr_d;
    end
  end

`ifdef ARB_TIMEOUT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_stall_cnt     <= '0;
      r_timeout_pulse <= 1'b0;
    end else begin
      r_stall_cnt     <= w_stall_cnt_d;
      r_timeout_pulse <= w_timeout_pulse_d;
    end
  end

  assign timeout_pulse = r_timeout_pulse;
`endif

  assign grant       = r_grant;
  assign grant_idx   = r_grant_idx;
  assign grant_valid = (r_state == StLocked);
  assign out_valid   = grant_valid && (|(r_grant & flit_valid));
  assign flit_ready  = r_grant & {NUM_IN{out_ready}};

endmodule

// File: tb/tb_output_port_arbiter.sv
module tb_output_port_arbiter;

  localparam int N   = 5;
  localparam int W   = 3;
  localparam int OID = 1;
  localparam int TO  = 8;

  logic             clk = 1'b0;
  logic             rst;
  logic [N-1:0]     req_valid;
  logic [N*W-1:0]   req_port;
  logic [N-1:0]     flit_valid;
  logic [N-1:0]     flit_tail;
  logic             out_ready;
  logic             out_valid;
  logic [N-1:0]     flit_ready;
  logic [N-1:0]     grant;
  logic [2:0]       grant_idx;
  logic             grant_valid;
`ifdef ARB_TIMEOUT_EN
  logic             timeout_pulse;
`endif

  int errors = 0;
  int checks = 0;

  // Reference model: the owning input (-1 when free), the round-robin start
  // index, and the consecutive stall count.
  int m_owner = -1;
  int m_ptr   = 0;
  int m_stall = 0;
  bit m_pulse = 1'b0;

  always #5 clk = ~clk;

  output_port_arbiter #(
    .NUM_IN(N), .REQUEST_WIDTH(W), .OUTPUT_ID(OID), .TIMEOUT(TO)
  ) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_port(req_port),
    .flit_valid(flit_valid), .flit_tail(flit_tail), .out_ready(out_ready),
    .out_valid(out_valid), .flit_ready(flit_ready), .grant(grant),
    .grant_idx(grant_idx), .grant_valid(grant_valid)
`ifdef ARB_TIMEOUT_EN
    , .timeout_pulse(timeout_pulse)
`endif
  );

  task automatic check_outputs(input string tag);
    logic [N-1:0] eg, efr;
    logic [2:0]   ei;
    logic         egv, eov;
    eg = '0; efr = '0; ei = '0; egv = 1'b0; eov = 1'b0;
    if (m_owner >= 0) begin
      eg[m_owner] = 1'b1;
      ei          = 3'(m_owner);
      egv         = 1'b1;
      eov         = flit_valid[m_owner];
      if (out_ready) efr[m_owner] = 1'b1;
    end
    checks++;
    assert (grant === eg) else begin
      errors++; $error("FAIL %s grant: got %b want %b", tag, grant, eg);
    end
    checks++;
    assert (grant_idx === ei) else begin
      errors++; $error("FAIL %s grant_idx: got %0d want %0d", tag, grant_idx, ei);
    end
    checks++;
    assert (grant_valid === egv) else begin
      errors++; $error("FAIL %s grant_valid: got %b want %b", tag, grant_valid, egv);
    end
    checks++;
    assert (out_valid === eov) else begin
      errors++; $error("FAIL %s out_valid: got %b want %b", tag, out_valid, eov);
    end
    checks++;
    assert (flit_ready === efr) else begin
      errors++; $error("FAIL %s flit_ready: got %b want %b", tag, flit_ready, efr);
    end
`ifdef ARB_TIMEOUT_EN
    checks++;
    assert (timeout_pulse === m_pulse) else begin
      errors++; $error("FAIL %s timeout_pulse: got %b want %b", tag, timeout_pulse, m_pulse);
    end
`endif
  endtask

  // Advance the model across the coming clock edge using the current inputs.
  task automatic model_step();
    int nxt;
    bit found;
    bit npulse;
    nxt    = m_owner;
    found  = 1'b0;
    npulse = 1'b0;
    if (m_owner < 0) begin
      m_stall = 0;
      for (int k = 0; k < N; k++) begin
        int j;
        j = (m_ptr + k) % N;
        if (!found && req_valid[j] && (int'(req_port[j*W +: W]) == OID)) begin
          found = 1'b1;
          nxt   = j;
        end
      end
    end else if (flit_valid[m_owner] && out_ready) begin
      m_stall = 0;
      if (flit_tail[m_owner]) begin
        m_ptr = (m_owner + 1) % N;
        nxt   = -1;
      end
    end else begin
      m_stall++;
`ifdef ARB_TIMEOUT_EN
      if (m_stall == TO) begin
        m_stall = 0;
        m_ptr   = (m_owner + 1) % N;
        nxt     = -1;
        npulse  = 1'b1;
      end
`endif
    end
    m_owner = nxt;
    m_pulse = npulse;
  endtask

  // Called at posedge+1 with inputs already applied; returns at the next posedge+1.
  task automatic tick(input string tag);
    #2;
    check_outputs(tag);
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_grant(input string tag, input logic [N-1:0] g, input logic gv);
    checks++;
    assert (grant === g) else begin
      errors++; $error("FAIL %s grant: got %b want %b", tag, grant, g);
    end
    checks++;
    assert (grant_valid === gv) else begin
      errors++; $error("FAIL %s grant_valid: got %b want %b", tag, grant_valid, gv);
    end
  endtask

  task automatic set_req(input int i, input int code);
    req_valid[i]       = 1'b1;
    req_port[i*W +: W] = 3'(code);
  endtask

  task automatic clear_inputs();
    req_valid  = '0;
    req_port   = '0;
    flit_valid = '0;
    flit_tail  = '0;
    out_ready  = 1'b1;
  endtask

  initial begin
    rst = 1'b1;
    clear_inputs();
    #2;
    check_outputs("reset");
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    tick("idle0");
    tick("idle1");

    // Single 3-flit packet on input 2.
    set_req(2, 1);
    flit_valid[2] = 1'b1;
    tick("pkt_arb");
    expect_grant("pkt_t1", 5'b00100, 1'b1);
    checks++;
    assert (grant_idx === 3'd2) else begin
      errors++; $error("FAIL pkt_t1 grant_idx: got %0d want 2", grant_idx);
    end
    req_valid = '0;
    tick("pkt_f1");
    tick("pkt_f2");
    flit_tail[2] = 1'b1;
    tick("pkt_f3");
    expect_grant("pkt_t4", 5'b00000, 1'b0);
    clear_inputs();
    tick("pkt_idle");

    // Asynchronous reset in the middle of a packet on input 2.
    set_req(2, 1);
    flit_valid[2] = 1'b1;
    tick("rst_arb");
    req_valid = '0;
    tick("rst_f1");
    expect_grant("rst_pre", 5'b00100, 1'b1);
    rst = 1'b1;
    m_owner = -1; m_ptr = 0; m_stall = 0; m_pulse = 1'b0;
    #1;
    check_outputs("rst_mid");
    expect_grant("rst_mid", 5'b00000, 1'b0);
    @(posedge clk);
    #1 rst = 1'b0;
    clear_inputs();

    // Round-robin: 0 and 3 contend with the pointer back at 0.
    set_req(0, 1);
    set_req(3, 1);
    flit_valid = '1;
    tick("rr_arb0");
    expect_grant("rr_first", 5'b00001, 1'b1);
    req_valid[0] = 1'b0;
    tick("rr_f1");
    flit_tail[0] = 1'b1;
    tick("rr_tail0");
    expect_grant("rr_bubble", 5'b00000, 1'b0);
    flit_tail = '0;
    tick("rr_arb3");
    expect_grant("rr_second", 5'b01000, 1'b1);
    req_valid = '0;

    // Backpressure mid-packet on input 3.
    out_ready = 1'b0;
    for (int c = 0; c < 4; c++) begin
      flit_valid[3] = c[0];
      tick("bp_stall");
    end
    expect_grant("bp_hold", 5'b01000, 1'b1);
    out_ready     = 1'b1;
    flit_valid[3] = 1'b1;
    flit_tail[3]  = 1'b1;
    tick("bp_tail");

    // Pointer now at 4: 0 and 4 contend, 4 wins.
    flit_tail = '0;
    set_req(0, 1);
    set_req(4, 1);
    tick("rr_arb4");
    expect_grant("rr_third", 5'b10000, 1'b1);
    req_valid = '0;
    flit_tail[4] = 1'b1;
    tick("rr_tail4");
    clear_inputs();

    // Filtering: input 1 routed elsewhere is never granted.
    set_req(1, 2);
    flit_valid[1] = 1'b1;
    for (int c = 0; c < 5; c++) tick("filt");
    expect_grant("filt_none", 5'b00000, 1'b0);
    set_req(0, 1);
    flit_valid[0] = 1'b1;
    flit_tail[0]  = 1'b1;
    tick("single_arb");
    expect_grant("single_lock", 5'b00001, 1'b1);
    req_valid[0] = 1'b0;
    tick("single_xfer");
    expect_grant("single_rel", 5'b00000, 1'b0);
    clear_inputs();
    tick("filt_idle");

`ifdef ARB_TIMEOUT_EN
    // Watchdog: input 2 is granted but never presents a flit.
    set_req(2, 1);
    tick("to_arb");
    req_valid = '0;
    for (int c = 0; c < TO; c++) tick("to_stall");
    checks++;
    assert (timeout_pulse === 1'b1) else begin
      errors++; $error("FAIL to_pulse: got %b want 1", timeout_pulse);
    end
    expect_grant("to_rel", 5'b00000, 1'b0);
    tick("to_after");
    checks++;
    assert (timeout_pulse === 1'b0) else begin
      errors++; $error("FAIL to_pulse_end: got %b want 0", timeout_pulse);
    end
`endif

    // Random traffic against the model.
    for (int c = 0; c < 800; c++) begin
      for (int i = 0; i < N; i++) begin
        req_valid[i]       = 1'($urandom_range(0, 1));
        req_port[i*W +: W] = 3'($urandom_range(0, 3));
        flit_valid[i]      = ($urandom_range(0, 3) != 0);
        flit_tail[i]       = ($urandom_range(0, 2) == 0);
      end
      out_ready = ($urandom_range(0, 3) != 0);
      tick("rand");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/output_port_arbiter.md
Name: output_port_arbiter

Overview:
- Per-output-port switch allocator for the router crossbar; one instance per output port.
- Collects route requests (output-port codes from each input's head flit decoder) and picks one input by round-robin.
- Holds the grant for the whole packet, head to tail, and drives the crossbar select and the flit valid/ready handshake for that output.

Parameters:
- NUM_IN, 5, number of router input ports (>= 2).
- REQUEST_WIDTH, 3, width of each route request code.
- OUTPUT_ID, 1, request code that selects this output port (0 = local ejection).
- TIMEOUT, 64, stall-cycle limit; used only with ARB_TIMEOUT_EN.

Ports:
- clk  input  1  clock.
- rst  input  1  asynchronous, active-high reset.
- req_valid  input  NUM_IN  input i holds a decoded head flit.
- req_port  input  NUM_IN*REQUEST_WIDTH  route code of input i, in slice [i*REQUEST_WIDTH +: REQUEST_WIDTH].
- flit_valid  input  NUM_IN  flit available at input i.
- flit_tail  input  NUM_IN  current flit of input i is its tail.
- out_ready  input  1  downstream accepts a flit this cycle.
- out_valid  output  1  flit presented on this output.
- flit_ready  output  NUM_IN  pop strobe to input i.
- grant  output  NUM_IN  one-hot granted input.
- grant_idx  output  $clog2(NUM_IN)  binary crossbar select.
- grant_valid  output  1  grant active (state LOCKED).
- timeout_pulse  output  1  present only with ARB_TIMEOUT_EN.

Behaviour:
- Reset (async, immediate, including mid-packet): state=IDLE, grant=0, grant_idx=0, grant_valid=0, rr_ptr=0, out_valid=0, flit_ready=0, timeout_pulse=0, stall counter=0.
- Candidate vector: cand[i] = req_valid[i] && (req_port slice i == OUTPUT_ID).
- IDLE:
  - If any cand: choose the first set bit scanning rr_ptr, rr_ptr+1, ... with wrap from NUM_IN-1 to 0.
  - Register the choice into grant and grant_idx, set grant_valid, go to LOCKED.
  - Latency: request at cycle t gives grant at t+1.
  - If no cand: stay IDLE; all outputs remain 0.
- LOCKED (granted input g):
  - out_valid = flit_valid[g], combinational.
  - flit_ready[g] = out_ready; all other flit_ready bits are 0.
  - Transfer occurs when flit_valid[g] && out_ready.
  - Transfer with flit_tail[g]=1: next cycle go to IDLE, clear grant, grant_idx and grant_valid, set rr_ptr = (g+1) mod NUM_IN.
  - Single-flit packet (head is tail) releases after its one transfer.
- Exactly one bubble cycle (IDLE) separates consecutive packets. No arbitration happens in the tail cycle.
- req_valid and req_port changes during LOCKED are ignored; the lock holds until tail (or timeout).
- out_ready=0: grant held, flit_ready=0, no state change.
- grant is always zero or one-hot; grant_idx always matches grant.
- Unused request codes (no matching OUTPUT_ID) are never granted. No error is flagged.

Optional Feature:
- Macro: ARB_TIMEOUT_EN.
- Defined:
  - Counter of width $clog2(TIMEOUT+1) increments every LOCKED cycle with no transfer and clears on any transfer or on release.
  - When the counter reaches TIMEOUT: next cycle go to IDLE, release the grant, advance rr_ptr past g, pulse timeout_pulse high for exactly 1 cycle, clear the counter.
- Undefined: no counter, no timeout_pulse port; the lock is held indefinitely until tail.

Test Plan (NUM_IN=5, REQUEST_WIDTH=3, OUTPUT_ID=1):
- Reset: assert rst mid-packet with grant=5'b00100 -> grant, grant_valid, out_valid, flit_ready all 0 immediately; rr_ptr=0 after release.
- Single packet: req_valid[2]=1, req_port[2]=1 at cycle t; 3-flit packet with out_ready=1 -> grant=5'b00100 and grant_idx=2 at t+1; transfers at t+1..t+3 with tail on t+3; grant_valid=0 at t+4.
- Round-robin: inputs 0 and 3 request simultaneously, rr_ptr=0 -> input 0 granted first; after its tail, one IDLE cycle, then grant=5'b01000; next contention between 0 and 4 with rr_ptr=4 -> input 4 wins.
- Backpressure: out_ready=0 for 4 cycles mid-packet -> grant stable, flit_ready=0, out_valid follows flit_valid[g], no release.
- Filtering: req_valid[1]=1 with req_port[1]=2 -> never granted; grant stays 0. A single-flit packet on input 0 with req_port=1 -> granted and released after 1 transfer.
- Timeout (ARB_TIMEOUT_EN, TIMEOUT=8): granted input holds flit_valid=0 -> timeout_pulse high for 1 cycle after 8 stall cycles; grant cleared; rr_ptr=g+1.
